// File: rtl/jtexterm_pal_pkg.sv
// Shared definitions for the palette sequencer: state encoding, palette byte
// layout and RGB555 field positions.
package jtexterm_pal_pkg;

  typedef enum logic [2:0] {
    ST_CLR  = 3'd0,
    ST_IDLE = 3'd1,
    ST_VHI  = 3'd2,
    ST_VLO  = 3'd3,
    ST_VCAP = 3'd4,
    ST_CPUA = 3'd5,
    ST_CPUW = 3'd6
  } pal_state_t;

  localparam int COL_W  = 15;
  localparam int RGB_W  = 5;
  // Even byte carries col[14:8] in bits 6:0; bit 7 is ignored.
  localparam int HI_MSB = 6;
  localparam int HI_LSB = 0;
  localparam int HI_W   = HI_MSB - HI_LSB + 1;
  localparam int R_MSB  = 14;
  localparam int R_LSB  = 10;
  localparam int G_MSB  = 9;
  localparam int G_LSB  = 5;
  localparam int B_MSB  = 4;
  localparam int B_LSB  = 0;

  function automatic logic [COL_W-1:0] pal_col(input logic [HI_W-1:0] hi,
                                               input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/jtexterm_pal_clr.sv
// Palette clear address generator: walks every RAM address once while enabled
// and flags the last one. Only used when JTEXTERM_PALCLR_EN is defined.
module jtexterm_pal_clr
  import jtexterm_pal_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  output logic [AW-1:0] o_addr,
  output logic          o_done
);

  logic [AW-1:0] r_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= '0;
    end else if (i_en) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  assign o_addr = r_addr;
  assign o_done = i_en & (&r_addr);

endmodule

// File: rtl/jtexterm_pal_ctrl.sv
// Palette RAM sequencer: arbitrates CPU accesses against per-pixel colour
// fetches and builds RGB555. Define JTEXTERM_PALCLR_EN to clear the RAM after reset.
module jtexterm_pal_ctrl
  import jtexterm_pal_pkg::*;
#(
  parameter int PXL_DIV = 4,
  parameter int AW      = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pxl_cen,
  input  logic             i_lhbl,
  input  logic             i_lvbl,
  input  logic [AW-2:0]    i_pal_idx,
  input  logic             i_cpu_cs,
  input  logic             i_cpu_rnw,
  input  logic [AW-1:0]    i_cpu_addr,
  input  logic [7:0]       i_cpu_dout,
  output logic [7:0]       o_cpu_din,
  output logic             o_cpu_ok,
  output logic [AW-1:0]    o_ram_addr,
  output logic [7:0]       o_ram_din,
  output logic             o_ram_we,
  input  logic [7:0]       i_ram_dout,
  output logic             o_clr_busy,
  output logic [RGB_W-1:0] o_red,
  output logic [RGB_W-1:0] o_green,
  output logic [RGB_W-1:0] o_blue,
  output logic [2:0]       o_dbg_state
);

  generate
    if (PXL_DIV < 4) begin : g_bad_div
      $error("PXL_DIV must be at least 4");
    end
  endgenerate

  pal_state_t       r_state, w_next;
  logic [AW-2:0]    r_idx;
  logic             r_vreq;
  logic             r_done;
  logic [AW-1:0]    r_cpu_addr;
  logic             r_cpu_rnw;
  logic [7:0]       r_cpu_wdata;
  logic [7:0]       r_cpu_din;
  logic [HI_W-1:0]  r_hi;
  logic [COL_W-1:0] r_col_next;
  logic [COL_W-1:0] r_rgb;
  logic [AW-1:0]    r_addr_hold;

  logic [AW-1:0]    w_ram_addr;
  logic [7:0]       w_ram_din;
  logic             w_ram_we;
  logic             w_clr_busy;
  logic             w_clr_done;
  logic [AW-1:0]    w_clr_addr;
  logic             w_active;
  logic             w_cen;
  logic             w_vstart;
  logic             w_cpu_ok;
  logic [COL_W-1:0] w_fetched;

`ifdef JTEXTERM_PALCLR_EN
  localparam pal_state_t RST_STATE = ST_CLR;

  jtexterm_pal_clr #(.AW(AW)) u_clr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (r_state == ST_CLR),
    .o_addr  (w_clr_addr),
    .o_done  (w_clr_done)
  );

  assign w_clr_busy = (r_state == ST_CLR);
`else
  localparam pal_state_t RST_STATE = ST_IDLE;

  assign w_clr_addr = '0;
  assign w_clr_done = 1'b0;
  assign w_clr_busy = 1'b0;
`endif

  assign w_active  = i_lhbl & i_lvbl;
  assign w_cen     = i_pxl_cen & ~w_clr_busy;
  assign w_vstart  = (w_cen & w_active) | r_vreq;
  assign w_fetched = pal_col(r_hi, i_ram_dout);

  // CPU handshake: i_cpu_cs is the request and stays high until o_cpu_ok.
  // o_cpu_ok pulses for the CPUW cycle only while i_cpu_cs is still high;
  // a new access needs i_cpu_cs low for at least one clk after o_cpu_ok.
  assign w_cpu_ok = (r_state == ST_CPUW) & i_cpu_cs;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CLR:  if (w_clr_done) w_next = ST_IDLE;
      ST_IDLE: begin
        if (w_vstart)                          w_next = ST_VHI;
        else if (i_cpu_cs && !r_done && !w_cen) w_next = ST_CPUA;
      end
      ST_VHI:  w_next = ST_VLO;
      ST_VLO:  w_next = ST_VCAP;
      ST_VCAP: w_next = ST_IDLE;
      ST_CPUA: w_next = ST_CPUW;
      ST_CPUW: w_next = w_vstart ? ST_VHI : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ram_addr = r_addr_hold;
    w_ram_din  = '0;
    w_ram_we   = 1'b0;
    case (r_state)
      ST_CLR: begin
        w_ram_addr = w_clr_addr;
        w_ram_we   = 1'b1;
      end
      ST_VHI:  w_ram_addr = {r_idx, 1'b0};
      ST_VLO:  w_ram_addr = {r_idx, 1'b1};
      ST_CPUA: begin
        w_ram_addr = r_cpu_addr;
        w_ram_we   = ~r_cpu_rnw;
        w_ram_din  = r_cpu_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= RST_STATE;
      r_idx       <= '0;
      r_vreq      <= 1'b0;
      r_done      <= 1'b0;
      r_cpu_addr  <= '0;
      r_cpu_rnw   <= 1'b1;
      r_cpu_wdata <= '0;
      r_cpu_din   <= '0;
      r_hi        <= '0;
      r_col_next  <= '0;
      r_rgb       <= '0;
      r_addr_hold <= '0;
    end else begin
      r_state     <= w_next;
      r_addr_hold <= w_ram_addr;

      if (r_state == ST_VLO)  r_hi       <= i_ram_dout[HI_MSB:HI_LSB];
      if (r_state == ST_VCAP) r_col_next <= w_fetched;
      if (r_state == ST_VHI)  r_vreq     <= 1'b0;

      // A fetch deferred behind a CPU access can finish on the very edge of
      // the next pixel, so the freshly fetched colour is forwarded.
      if (w_cen) begin
        r_rgb <= (r_state == ST_VCAP) ? w_fetched : r_col_next;
        if (w_active) begin
          r_idx  <= i_pal_idx;
          r_vreq <= 1'b1;
        end else begin
          r_col_next <= '0;
        end
      end

      if (r_state == ST_IDLE && w_next == ST_CPUA) begin
        r_cpu_addr  <= i_cpu_addr;
        r_cpu_rnw   <= i_cpu_rnw;
        r_cpu_wdata <= i_cpu_dout;
      end

      if (w_cpu_ok) begin
        r_done <= 1'b1;
        if (r_cpu_rnw) r_cpu_din <= i_ram_dout;
      end else if (!i_cpu_cs) begin
        r_done <= 1'b0;
      end
    end
  end

  assign o_cpu_ok    = w_cpu_ok;
  assign o_cpu_din   = (w_cpu_ok && r_cpu_rnw) ? i_ram_dout : r_cpu_din;
  assign o_ram_addr  = w_ram_addr;
  assign o_ram_din   = w_ram_din;
  assign o_ram_we    = w_ram_we;
  assign o_clr_busy  = w_clr_busy;
  assign o_red       = r_rgb[R_MSB:R_LSB];
  assign o_green     = r_rgb[G_MSB:G_LSB];
  assign o_blue      = r_rgb[B_MSB:B_LSB];
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_jtexterm_pal_ctrl.sv
// Directed bench for jtexterm_pal_ctrl with a synchronous 1Kx8 RAM model.
module tb_jtexterm_pal_ctrl;
  import jtexterm_pal_pkg::*;

  localparam int PXL_DIV = 4;
  localparam int AW      = 10;

`ifdef JTEXTERM_PALCLR_EN
  localparam logic [2:0] EXP_RST_STATE = 3'd0;
  localparam logic       EXP_RST_BUSY  = 1'b1;
  localparam logic       EXP_RST_WE    = 1'b1;
  localparam logic [7:0] EXP_AFTER_RST = 8'h00;
`else
  localparam logic [2:0] EXP_RST_STATE = 3'd1;
  localparam logic       EXP_RST_BUSY  = 1'b0;
  localparam logic       EXP_RST_WE    = 1'b0;
  localparam logic [7:0] EXP_AFTER_RST = 8'h1F;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_pxl_cen = 1'b0;
  logic          i_lhbl = 1'b1;
  logic          i_lvbl = 1'b1;
  logic [AW-2:0] i_pal_idx = '0;
  logic          i_cpu_cs = 1'b0;
  logic          i_cpu_rnw = 1'b1;
  logic [AW-1:0] i_cpu_addr = '0;
  logic [7:0]    i_cpu_dout = '0;
  logic [7:0]    o_cpu_din;
  logic          o_cpu_ok;
  logic [AW-1:0] o_ram_addr;
  logic [7:0]    o_ram_din;
  logic          o_ram_we;
  logic [7:0]    i_ram_dout = 8'h00;
  logic          o_clr_busy;
  logic [4:0]    o_red, o_green, o_blue;
  logic [2:0]    o_dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:1023] = '{default: 8'hC3};

  jtexterm_pal_ctrl #(.PXL_DIV(PXL_DIV), .AW(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pxl_cen(i_pxl_cen),
    .i_lhbl(i_lhbl), .i_lvbl(i_lvbl), .i_pal_idx(i_pal_idx),
    .i_cpu_cs(i_cpu_cs), .i_cpu_rnw(i_cpu_rnw), .i_cpu_addr(i_cpu_addr),
    .i_cpu_dout(i_cpu_dout), .o_cpu_din(o_cpu_din), .o_cpu_ok(o_cpu_ok),
    .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din), .o_ram_we(o_ram_we),
    .i_ram_dout(i_ram_dout), .o_clr_busy(o_clr_busy),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_dbg_state(o_dbg_state)
  );

  // clock / RAM model
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_ram_we) mem[o_ram_addr] <= o_ram_din;
    i_ram_dout <= mem[o_ram_addr];
  end

  // driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_clear();
    for (int n = 0; n < 1100 && o_clr_busy; n++) tick();
    checks++;
    if (o_clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_timeout clr_busy=%b required 0", o_clr_busy);
    end
  endtask

  task automatic cpu_access(input logic rnw, input logic [9:0] addr,
                            input logic [7:0] wd, output logic [7:0] rd);
    bit got;
    got = 1'b0;
    rd  = 8'h00;
    i_cpu_cs = 1'b1; i_cpu_rnw = rnw; i_cpu_addr = addr; i_cpu_dout = wd;
    for (int n = 0; n < 64 && !got; n++) begin
      tick();
      if (o_cpu_ok) begin
        got = 1'b1;
        rd  = o_cpu_din;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL cpu_ok_timeout addr=%h got no pulse required one", addr);
    end
    tick();
    i_cpu_cs = 1'b0;
    tick();
  endtask

  task automatic pixel(input logic [8:0] idx, input logic hb, input logic vb);
    i_pal_idx = idx; i_lhbl = hb; i_lvbl = vb; i_pxl_cen = 1'b1;
    tick();
    i_pxl_cen = 1'b0;
    repeat (PXL_DIV - 1) tick();
  endtask

  // scenarios
  task automatic test_reset();
    i_rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({o_red, o_green, o_blue} !== 15'h0000) begin
      errors++; $display("FAIL rst_rgb got=%h required 0000", {o_red, o_green, o_blue});
    end
    checks++;
    if ({o_cpu_ok, o_cpu_din, o_ram_addr, o_ram_din} !== 27'h0) begin
      errors++;
      $display("FAIL rst_bus got ok=%b din=%h addr=%h wdata=%h required all 0",
               o_cpu_ok, o_cpu_din, o_ram_addr, o_ram_din);
    end
    checks++;
    if (o_ram_we !== EXP_RST_WE) begin
      errors++; $display("FAIL rst_we got=%b required %b", o_ram_we, EXP_RST_WE);
    end
    checks++;
    if (o_dbg_state !== EXP_RST_STATE) begin
      errors++; $display("FAIL rst_state got=%0d required %0d", o_dbg_state, EXP_RST_STATE);
    end
    checks++;
    if (o_clr_busy !== EXP_RST_BUSY) begin
      errors++; $display("FAIL rst_busy got=%b required %b", o_clr_busy, EXP_RST_BUSY);
    end
    i_rst_n = 1'b1;
    wait_clear();
    checks++;
    if (o_dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL post_rst_state got=%0d required %0d", o_dbg_state, ST_IDLE);
    end
  endtask

`ifdef JTEXTERM_PALCLR_EN
  task automatic test_clear();
    int busy_cnt;
    int ok_busy;
    bit got;
    logic [7:0] rd;
    busy_cnt = 0; ok_busy = 0; got = 1'b0;
    i_rst_n = 1'b0;
    tick();
    i_cpu_cs = 1'b1; i_cpu_rnw = 1'b0; i_cpu_addr = 10'd5; i_cpu_dout = 8'hAA;
    tick();
    i_rst_n = 1'b1;
    for (int n = 0; n < 1100 && o_clr_busy; n++) begin
      busy_cnt++;
      if (o_cpu_ok) ok_busy++;
      tick();
    end
    checks++;
    if (busy_cnt != 1024) begin
      errors++; $display("FAIL clr_len got=%0d required 1024", busy_cnt);
    end
    checks++;
    if (ok_busy != 0) begin
      errors++; $display("FAIL clr_ok_stall got=%0d pulses required 0", ok_busy);
    end
    for (int n = 0; n < 10 && !got; n++) begin
      if (o_cpu_ok) got = 1'b1;
      else tick();
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL clr_write_ok got none required pulse");
    end
    tick();
    i_cpu_cs = 1'b0;
    tick();
    cpu_access(1'b1, 10'd5, 8'h00, rd);
    checks++;
    if (rd !== 8'hAA) begin
      errors++; $display("FAIL clr_read5 got=%h required aa", rd);
    end
    cpu_access(1'b1, 10'd6, 8'h00, rd);
    checks++;
    if (rd !== 8'h00) begin
      errors++; $display("FAIL clr_read6 got=%h required 00", rd);
    end
  endtask
`endif

  task automatic test_colour();
    logic [7:0] rd;
    cpu_access(1'b0, 10'h010, 8'h7C, rd);
    cpu_access(1'b0, 10'h011, 8'h1F, rd);
    pixel(9'd8, 1'b1, 1'b1);
    checks++;
    if ({o_red, o_green, o_blue} !== 15'h0000) begin
      errors++; $display("FAIL colour_latency got=%h required 0000", {o_red, o_green, o_blue});
    end
    pixel(9'd8, 1'b1, 1'b1);
    checks++;
    if (o_red !== 5'd31 || o_green !== 5'd0 || o_blue !== 5'd31) begin
      errors++;
      $display("FAIL colour_idx8 got r=%0d g=%0d b=%0d required 31 0 31", o_red, o_green, o_blue);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    cpu_access(1'b0, 10'h020, 8'hFF, rd);
    cpu_access(1'b0, 10'h021, 8'h00, rd);
    cpu_access(1'b0, 10'h030, 8'h15, rd);
    cpu_access(1'b0, 10'h031, 8'hAA, rd);
    pixel(9'd16, 1'b1, 1'b1);
    checks++;
    if ({o_red, o_green, o_blue} !== 15'h7C1F) begin
      errors++; $display("FAIL b2b_0 got=%h required 7c1f", {o_red, o_green, o_blue});
    end
    pixel(9'd24, 1'b1, 1'b1);
    checks++;
    if (o_red !== 5'd31 || o_green !== 5'd24 || o_blue !== 5'd0) begin
      errors++;
      $display("FAIL b2b_bit7 got r=%0d g=%0d b=%0d required 31 24 0", o_red, o_green, o_blue);
    end
    pixel(9'd24, 1'b1, 1'b1);
    checks++;
    if (o_red !== 5'd5 || o_green !== 5'd13 || o_blue !== 5'd10) begin
      errors++;
      $display("FAIL b2b_idx24 got r=%0d g=%0d b=%0d required 5 13 10", o_red, o_green, o_blue);
    end
  endtask

  task automatic test_blank();
    int we_cnt;
    int busy_cyc;
    we_cnt = 0; busy_cyc = 0;
    i_pal_idx = 9'd8; i_lhbl = 1'b1; i_lvbl = 1'b0; i_pxl_cen = 1'b1;
    tick();
    i_pxl_cen = 1'b0;
    checks++;
    if ({o_red, o_green, o_blue} !== 15'h15AA) begin
      errors++; $display("FAIL blank_prev got=%h required 15aa", {o_red, o_green, o_blue});
    end
    for (int n = 0; n < PXL_DIV; n++) begin
      if (o_ram_we) we_cnt++;
      if (o_dbg_state !== ST_IDLE) busy_cyc++;
      if (n < PXL_DIV - 1) tick();
    end
    checks++;
    if (we_cnt != 0 || busy_cyc != 0) begin
      errors++; $display("FAIL blank_noaccess got we=%0d fetch=%0d required 0 0", we_cnt, busy_cyc);
    end
    checks++;
    if (o_ram_addr !== 10'h031) begin
      errors++; $display("FAIL blank_addr_hold got=%h required 031", o_ram_addr);
    end
    pixel(9'd8, 1'b1, 1'b0);
    checks++;
    if ({o_red, o_green, o_blue} !== 15'h0000) begin
      errors++; $display("FAIL blank_rgb got=%h required 0000", {o_red, o_green, o_blue});
    end
    pixel(9'd8, 1'b1, 1'b1);
    checks++;
    if ({o_red, o_green, o_blue} !== 15'h0000) begin
      errors++; $display("FAIL blank_exit got=%h required 0000", {o_red, o_green, o_blue});
    end
  endtask

  task automatic test_cpu_vs_pixel();
    int vhi_at;
    int ok_at;
    logic [7:0] rd;
    vhi_at = -1; ok_at = -1; rd = 8'h00;
    i_pal_idx = 9'd8; i_lhbl = 1'b1; i_lvbl = 1'b1; i_pxl_cen = 1'b1;
    i_cpu_cs = 1'b1; i_cpu_rnw = 1'b1; i_cpu_addr = 10'h011;
    for (int n = 1; n <= 20 && ok_at < 0; n++) begin
      tick();
      i_pxl_cen = 1'b0;
      if (o_dbg_state === ST_VHI && vhi_at < 0) vhi_at = n;
      if (o_cpu_ok) begin
        ok_at = n;
        rd = o_cpu_din;
      end
    end
    tick();
    i_cpu_cs = 1'b0;
    tick();
    checks++;
    if (vhi_at !== 1) begin
      errors++; $display("FAIL cvp_video_first got vhi_cycle=%0d required 1", vhi_at);
    end
    checks++;
    if (ok_at < 1 || ok_at > PXL_DIV + 2) begin
      errors++; $display("FAIL cvp_wait got=%0d required 1..%0d", ok_at, PXL_DIV + 2);
    end
    checks++;
    if (rd !== 8'h1F) begin
      errors++; $display("FAIL cvp_rdata got=%h required 1f", rd);
    end
    pixel(9'd8, 1'b1, 1'b1);
    checks++;
    if ({o_red, o_green, o_blue} !== 15'h7C1F) begin
      errors++; $display("FAIL cvp_rgb got=%h required 7c1f", {o_red, o_green, o_blue});
    end
  endtask

  task automatic test_deferred();
    logic [7:0] rd;
    i_cpu_cs = 1'b1; i_cpu_rnw = 1'b0; i_cpu_addr = 10'h040; i_cpu_dout = 8'h12;
    tick();
    checks++;
    if (o_dbg_state !== ST_CPUA) begin
      errors++; $display("FAIL def_cpua got=%0d required %0d", o_dbg_state, ST_CPUA);
    end
    i_pal_idx = 9'd24; i_lhbl = 1'b1; i_lvbl = 1'b1; i_pxl_cen = 1'b1;
    tick();
    i_pxl_cen = 1'b0;
    checks++;
    if (o_cpu_ok !== 1'b1) begin
      errors++; $display("FAIL def_ok got=%b required 1", o_cpu_ok);
    end
    tick();
    i_cpu_cs = 1'b0;
    tick(); tick();
    i_pxl_cen = 1'b1;
    tick();
    i_pxl_cen = 1'b0;
    checks++;
    if (o_red !== 5'd5 || o_green !== 5'd13 || o_blue !== 5'd10) begin
      errors++;
      $display("FAIL def_rgb got r=%0d g=%0d b=%0d required 5 13 10", o_red, o_green, o_blue);
    end
    repeat (PXL_DIV) tick();
    cpu_access(1'b1, 10'h040, 8'h00, rd);
    checks++;
    if (rd !== 8'h12) begin
      errors++; $display("FAIL def_write got=%h required 12", rd);
    end
  endtask

  task automatic test_cs_glitch();
    int we_cnt;
    int ok_cnt;
    logic [7:0] rd;
    we_cnt = 0; ok_cnt = 0;
    i_pal_idx = 9'd8; i_lhbl = 1'b1; i_lvbl = 1'b1; i_pxl_cen = 1'b1;
    tick();
    i_pxl_cen = 1'b0;
    checks++;
    if (o_dbg_state !== ST_VHI) begin
      errors++; $display("FAIL glitch_vhi got=%0d required %0d", o_dbg_state, ST_VHI);
    end
    i_cpu_cs = 1'b1; i_cpu_rnw = 1'b0; i_cpu_addr = 10'h010; i_cpu_dout = 8'h55;
    tick();
    i_cpu_cs = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (o_ram_we) we_cnt++;
      if (o_cpu_ok) ok_cnt++;
      tick();
    end
    checks++;
    if (we_cnt != 0 || ok_cnt != 0) begin
      errors++; $display("FAIL glitch_access got we=%0d ok=%0d required 0 0", we_cnt, ok_cnt);
    end
    cpu_access(1'b1, 10'h010, 8'h00, rd);
    checks++;
    if (rd !== 8'h7C) begin
      errors++; $display("FAIL glitch_ram got=%h required 7c", rd);
    end
  endtask

  task automatic test_reset_in_cpua();
    int ok_cnt;
    logic [7:0] rd;
    ok_cnt = 0;
    i_cpu_cs = 1'b1; i_cpu_rnw = 1'b1; i_cpu_addr = 10'h011;
    tick();
    checks++;
    if (o_dbg_state !== ST_CPUA) begin
      errors++; $display("FAIL rcpua_state got=%0d required %0d", o_dbg_state, ST_CPUA);
    end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_cpu_ok !== 1'b0 || o_cpu_din !== 8'h00 || o_ram_addr !== 10'h000) begin
      errors++;
      $display("FAIL rcpua_outs got ok=%b din=%h addr=%h required 0 00 000",
               o_cpu_ok, o_cpu_din, o_ram_addr);
    end
    checks++;
    if ({o_red, o_green, o_blue} !== 15'h0000 || o_ram_we !== EXP_RST_WE) begin
      errors++;
      $display("FAIL rcpua_rgb got rgb=%h we=%b required 0000 %b",
               {o_red, o_green, o_blue}, o_ram_we, EXP_RST_WE);
    end
    checks++;
    if (o_dbg_state !== EXP_RST_STATE) begin
      errors++; $display("FAIL rcpua_rst_state got=%0d required %0d", o_dbg_state, EXP_RST_STATE);
    end
    for (int n = 0; n < 3; n++) begin
      tick();
      if (o_cpu_ok) ok_cnt++;
    end
    i_cpu_cs = 1'b0;
    i_rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      if (o_cpu_ok) ok_cnt++;
      tick();
    end
    checks++;
    if (ok_cnt != 0) begin
      errors++; $display("FAIL rcpua_no_ok got=%0d pulses required 0", ok_cnt);
    end
    wait_clear();
    cpu_access(1'b1, 10'h011, 8'h00, rd);
    checks++;
    if (rd !== EXP_AFTER_RST) begin
      errors++; $display("FAIL rcpua_restart got=%h required %h", rd, EXP_AFTER_RST);
    end
  endtask

  initial begin
    test_reset();
`ifdef JTEXTERM_PALCLR_EN
    test_clear();
`endif
    test_colour();
    test_back_to_back();
    test_blank();
    test_cpu_vs_pixel();
    test_deferred();
    test_cs_glitch();
    test_reset_in_cpua();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
